// File: rtl/core_alu_arbiter_if.sv
// Request/response/ALU bundle shared between two requesters, the arbiter and a shared ALU.
// The slave modport is the arbiter's view; master is the requester/ALU side.
interface core_alu_arbiter_if #(
    parameter int TAG_W = 4
);
    logic             req0_valid_i;
    logic             req1_valid_i;
    logic             req0_ready_o;
    logic             req1_ready_o;
    logic [1:0]       req0_grand_op_i;
    logic [1:0]       req1_grand_op_i;
    logic [1:0]       req0_op_i;
    logic [1:0]       req1_op_i;
    logic [31:0]      req0_r0_i;
    logic [31:0]      req1_r0_i;
    logic [31:0]      req0_r1_i;
    logic [31:0]      req1_r1_i;
    logic [31:0]      req0_pc_i;
    logic [31:0]      req1_pc_i;
    logic [TAG_W-1:0] req0_tag_i;
    logic [TAG_W-1:0] req1_tag_i;

    logic [1:0]       alu_grand_op_o;
    logic [1:0]       alu_op_o;
    logic [31:0]      alu_r0_o;
    logic [31:0]      alu_r1_o;
    logic [31:0]      alu_pc_o;
    logic [31:0]      alu_res_i;

    logic             rsp0_valid_o;
    logic             rsp1_valid_o;
    logic             rsp0_ready_i;
    logic             rsp1_ready_i;
    logic [31:0]      rsp0_res_o;
    logic [31:0]      rsp1_res_o;
    logic [TAG_W-1:0] rsp0_tag_o;
    logic [TAG_W-1:0] rsp1_tag_o;

    modport slave (
        input  req0_valid_i, req1_valid_i,
        input  req0_grand_op_i, req1_grand_op_i, req0_op_i, req1_op_i,
        input  req0_r0_i, req1_r0_i, req0_r1_i, req1_r1_i, req0_pc_i, req1_pc_i,
        input  req0_tag_i, req1_tag_i,
        output req0_ready_o, req1_ready_o,
        output alu_grand_op_o, alu_op_o, alu_r0_o, alu_r1_o, alu_pc_o,
        input  alu_res_i,
        output rsp0_valid_o, rsp1_valid_o, rsp0_res_o, rsp1_res_o, rsp0_tag_o, rsp1_tag_o,
        input  rsp0_ready_i, rsp1_ready_i
    );

    modport master (
        output req0_valid_i, req1_valid_i,
        output req0_grand_op_i, req1_grand_op_i, req0_op_i, req1_op_i,
        output req0_r0_i, req1_r0_i, req0_r1_i, req1_r1_i, req0_pc_i, req1_pc_i,
        output req0_tag_i, req1_tag_i,
        input  req0_ready_o, req1_ready_o,
        input  alu_grand_op_o, alu_op_o, alu_r0_o, alu_r1_o, alu_pc_o,
        output alu_res_i,
        input  rsp0_valid_o, rsp1_valid_o, rsp0_res_o, rsp1_res_o, rsp0_tag_o, rsp1_tag_o,
        output rsp0_ready_i, rsp1_ready_i
    );
endinterface

// File: rtl/core_alu_arbiter.sv
// Two-requester arbiter for one shared combinational ALU, one result slot per requester.
// Latency: grant and ALU drive same cycle, rsp_valid one cycle after grant.
// Backpressure: a port is granted only if its slot is empty or drained this cycle; CORE_ALU_ARB_FIXED_PRIO_EN makes port 0 win ties.
module core_alu_arbiter #(
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    core_alu_arbiter_if.slave    bus
);

    typedef struct packed {
        logic [1:0]       grand_op;
        logic [1:0]       op;
        logic [31:0]      r0;
        logic [31:0]      r1;
        logic [31:0]      pc;
        logic [TAG_W-1:0] tag;
    } alu_req_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    alu_req_t         req_dat [2];
    alu_req_t         sel_dat;
    logic [1:0]       req_vld;
    logic [1:0]       rsp_rdy;
    logic [1:0]       elig;
    logic [1:0]       gnt;

    slot_state_t      slot_state [2];
    logic [31:0]      slot_res   [2];
    logic [TAG_W-1:0] slot_tag   [2];

    assign req_dat[0] = {bus.req0_grand_op_i, bus.req0_op_i, bus.req0_r0_i,
                         bus.req0_r1_i, bus.req0_pc_i, bus.req0_tag_i};
    assign req_dat[1] = {bus.req1_grand_op_i, bus.req1_op_i, bus.req1_r0_i,
                         bus.req1_r1_i, bus.req1_pc_i, bus.req1_tag_i};
    assign req_vld    = {bus.req1_valid_i, bus.req0_valid_i};
    assign rsp_rdy    = {bus.rsp1_ready_i, bus.rsp0_ready_i};

    // A full slot frees up in the same cycle it is drained, so no bubble between results.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            elig[i] = req_vld[i] && ((slot_state[i] == SLOT_EMPTY) || rsp_rdy[i]);
        end
    end

`ifdef CORE_ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            gnt[0] = elig[0];
            gnt[1] = elig[1] && !elig[0];
        end
    end
`else
    // last_grant: 0 = port 0 granted most recently, 1 = port 1.
    logic last_grant;

    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            if (elig[0] && elig[1]) begin
                gnt[0] = last_grant;
                gnt[1] = !last_grant;
            end else begin
                gnt = elig;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (gnt[0]) begin
            last_grant <= 1'b0;
        end else if (gnt[1]) begin
            last_grant <= 1'b1;
        end
    end
`endif

    // Idle cycles present port 0 to the ALU; its result is simply not captured.
    assign sel_dat = gnt[1] ? req_dat[1] : req_dat[0];

    assign bus.alu_grand_op_o = sel_dat.grand_op;
    assign bus.alu_op_o       = sel_dat.op;
    assign bus.alu_r0_o       = sel_dat.r0;
    assign bus.alu_r1_o       = sel_dat.r1;
    assign bus.alu_pc_o       = sel_dat.pc;

    assign bus.req0_ready_o   = gnt[0];
    assign bus.req1_ready_o   = gnt[1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                slot_state[i] <= SLOT_EMPTY;
                slot_res[i]   <= '0;
                slot_tag[i]   <= '0;
            end else begin
                case (slot_state[i])
                    SLOT_EMPTY: begin
                        if (gnt[i]) begin
                            slot_state[i] <= SLOT_FULL;
                            slot_res[i]   <= bus.alu_res_i;
                            slot_tag[i]   <= sel_dat.tag;
                        end
                    end
                    SLOT_FULL: begin
                        if (gnt[i]) begin
                            slot_res[i]   <= bus.alu_res_i;
                            slot_tag[i]   <= sel_dat.tag;
                        end else if (rsp_rdy[i]) begin
                            slot_state[i] <= SLOT_EMPTY;
                        end
                    end
                    default: slot_state[i] <= SLOT_EMPTY;
                endcase
            end
        end
    end

    assign bus.rsp0_valid_o = (slot_state[0] == SLOT_FULL);
    assign bus.rsp1_valid_o = (slot_state[1] == SLOT_FULL);
    assign bus.rsp0_res_o   = slot_res[0];
    assign bus.rsp1_res_o   = slot_res[1];
    assign bus.rsp0_tag_o   = slot_tag[0];
    assign bus.rsp1_tag_o   = slot_tag[1];

endmodule

// File: tb/tb_core_alu_arbiter.sv
// Directed bench for core_alu_arbiter with a small combinational ALU model on the shared port.
// Expected grants follow the CORE_ALU_ARB_FIXED_PRIO_EN setting of the build.
module tb_core_alu_arbiter;

    localparam int TAG_W = 4;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    core_alu_arbiter_if #(.TAG_W(TAG_W)) bus ();

    core_alu_arbiter #(.TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: group 0 = add/sub/and/or, group 1 = xor/shl/shr/pc+r0, otherwise pc+4.
    always_comb begin
        bus.alu_res_i = bus.alu_pc_o + 32'd4;
        if (bus.alu_grand_op_o == 2'd0) begin
            case (bus.alu_op_o)
                2'd0:    bus.alu_res_i = bus.alu_r0_o + bus.alu_r1_o;
                2'd1:    bus.alu_res_i = bus.alu_r0_o - bus.alu_r1_o;
                2'd2:    bus.alu_res_i = bus.alu_r0_o & bus.alu_r1_o;
                default: bus.alu_res_i = bus.alu_r0_o | bus.alu_r1_o;
            endcase
        end else if (bus.alu_grand_op_o == 2'd1) begin
            case (bus.alu_op_o)
                2'd0:    bus.alu_res_i = bus.alu_r0_o ^ bus.alu_r1_o;
                2'd1:    bus.alu_res_i = bus.alu_r0_o << bus.alu_r1_o[4:0];
                2'd2:    bus.alu_res_i = bus.alu_r0_o >> bus.alu_r1_o[4:0];
                default: bus.alu_res_i = bus.alu_pc_o + bus.alu_r0_o;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic vld, input logic [1:0] gop, input logic [1:0] op,
                          input logic [31:0] r0, input logic [31:0] r1,
                          input logic [31:0] pc, input logic [TAG_W-1:0] tag);
        bus.req0_valid_i = vld; bus.req0_grand_op_i = gop; bus.req0_op_i = op;
        bus.req0_r0_i = r0; bus.req0_r1_i = r1; bus.req0_pc_i = pc; bus.req0_tag_i = tag;
    endtask

    task automatic drive1(input logic vld, input logic [1:0] gop, input logic [1:0] op,
                          input logic [31:0] r0, input logic [31:0] r1,
                          input logic [31:0] pc, input logic [TAG_W-1:0] tag);
        bus.req1_valid_i = vld; bus.req1_grand_op_i = gop; bus.req1_op_i = op;
        bus.req1_r0_i = r0; bus.req1_r1_i = r1; bus.req1_pc_i = pc; bus.req1_tag_i = tag;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.rsp0_ready_i = 1'b0;
        bus.rsp1_ready_i = 1'b0;
        drive0(1'b1, 2'd0, 2'd0, 32'd1, 32'd1, 32'd0, 4'd1);
        drive1(1'b1, 2'd0, 2'd0, 32'd2, 32'd2, 32'd0, 4'd2);
        step();
        step();
        @(negedge clk);
        vectors++; if (bus.req0_ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_req0_ready got %b want 0", bus.req0_ready_o); end
        vectors++; if (bus.req1_ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_req1_ready got %b want 0", bus.req1_ready_o); end
        vectors++; if (bus.rsp0_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_rsp0_valid got %b want 0", bus.rsp0_valid_o); end
        vectors++; if (bus.rsp1_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_rsp1_valid got %b want 0", bus.rsp1_valid_o); end
        vectors++; if (bus.rsp0_res_o !== 32'd0) begin miscompares++; $display("FAIL reset_rsp0_res got %0h want 0", bus.rsp0_res_o); end
        vectors++; if (bus.rsp1_tag_o !== 4'd0) begin miscompares++; $display("FAIL reset_rsp1_tag got %0h want 0", bus.rsp1_tag_o); end
        step();
        rst = 1'b0;
        drive0(1'b0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 4'd0);
        drive1(1'b0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 4'd0);
    endtask

    // Both ports valid every cycle and drained every cycle: 10+20=30 tag 1 vs 50-8=42 tag 9.
    task automatic test_round_robin();
        logic g;
        bus.rsp0_ready_i = 1'b1;
        bus.rsp1_ready_i = 1'b1;
        drive0(1'b1, 2'd0, 2'd0, 32'd10, 32'd20, 32'd0, 4'd1);
        drive1(1'b1, 2'd0, 2'd1, 32'd50, 32'd8, 32'd0, 4'd9);
        for (int i = 0; i < 4; i++) begin
`ifdef CORE_ALU_ARB_FIXED_PRIO_EN
            g = 1'b0;
`else
            g = (i % 2 == 1);
`endif
            @(negedge clk);
            vectors++; if (bus.req0_ready_o !== !g) begin miscompares++; $display("FAIL rr_req0_ready cyc %0d got %b want %b", i, bus.req0_ready_o, !g); end
            vectors++; if (bus.req1_ready_o !== g) begin miscompares++; $display("FAIL rr_req1_ready cyc %0d got %b want %b", i, bus.req1_ready_o, g); end
            step();
            if (!g) begin
                vectors++; if (bus.rsp0_valid_o !== 1'b1 || bus.rsp0_res_o !== 32'd30 || bus.rsp0_tag_o !== 4'd1) begin miscompares++; $display("FAIL rr_rsp0 cyc %0d got v=%b res=%0d tag=%0d want v=1 res=30 tag=1", i, bus.rsp0_valid_o, bus.rsp0_res_o, bus.rsp0_tag_o); end
                vectors++; if (bus.rsp1_valid_o !== 1'b0) begin miscompares++; $display("FAIL rr_rsp1_valid cyc %0d got %b want 0", i, bus.rsp1_valid_o); end
            end else begin
                vectors++; if (bus.rsp1_valid_o !== 1'b1 || bus.rsp1_res_o !== 32'd42 || bus.rsp1_tag_o !== 4'd9) begin miscompares++; $display("FAIL rr_rsp1 cyc %0d got v=%b res=%0d tag=%0d want v=1 res=42 tag=9", i, bus.rsp1_valid_o, bus.rsp1_res_o, bus.rsp1_tag_o); end
                vectors++; if (bus.rsp0_valid_o !== 1'b0) begin miscompares++; $display("FAIL rr_rsp0_valid cyc %0d got %b want 0", i, bus.rsp0_valid_o); end
            end
        end
        drive0(1'b0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 4'd0);
        drive1(1'b0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 4'd0);
        step();
        vectors++; if (bus.rsp0_valid_o !== 1'b0 || bus.rsp1_valid_o !== 1'b0) begin miscompares++; $display("FAIL rr_drain got v0=%b v1=%b want 0 0", bus.rsp0_valid_o, bus.rsp1_valid_o); end
    endtask

    // ADD r0=3 r1=5 tag 2 -> 8 tag 2 one cycle later.
    task automatic test_single();
        drive0(1'b1, 2'd0, 2'd0, 32'd3, 32'd5, 32'd0, 4'd2);
        @(negedge clk);
        vectors++; if (bus.req0_ready_o !== 1'b1) begin miscompares++; $display("FAIL single_req0_ready got %b want 1", bus.req0_ready_o); end
        vectors++; if (bus.req1_ready_o !== 1'b0) begin miscompares++; $display("FAIL single_req1_ready got %b want 0", bus.req1_ready_o); end
        step();
        drive0(1'b0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 4'd0);
        vectors++; if (bus.rsp0_valid_o !== 1'b1) begin miscompares++; $display("FAIL single_rsp0_valid got %b want 1", bus.rsp0_valid_o); end
        vectors++; if (bus.rsp0_res_o !== 32'd8) begin miscompares++; $display("FAIL single_rsp0_res got %0d want 8", bus.rsp0_res_o); end
        vectors++; if (bus.rsp0_tag_o !== 4'd2) begin miscompares++; $display("FAIL single_rsp0_tag got %0d want 2", bus.rsp0_tag_o); end
        step();
        vectors++; if (bus.rsp0_valid_o !== 1'b0) begin miscompares++; $display("FAIL single_drain got %b want 0", bus.rsp0_valid_o); end
    endtask

    // Slot 0 full and stalled: port 0 refused, its result held, port 1 still served.
    task automatic test_hold();
        bus.rsp0_ready_i = 1'b0;
        bus.rsp1_ready_i = 1'b0;
        drive0(1'b1, 2'd0, 2'd2, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 4'd3);
        step();
        drive0(1'b1, 2'd1, 2'd0, 32'd1, 32'd2, 32'd0, 4'd11);
        drive1(1'b1, 2'd1, 2'd1, 32'd1, 32'd4, 32'd0, 4'd5);
        @(negedge clk);
        vectors++; if (bus.req0_ready_o !== 1'b0) begin miscompares++; $display("FAIL hold_req0_ready got %b want 0", bus.req0_ready_o); end
        vectors++; if (bus.req1_ready_o !== 1'b1) begin miscompares++; $display("FAIL hold_req1_ready got %b want 1", bus.req1_ready_o); end
        step();
        drive0(1'b0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 4'd0);
        drive1(1'b0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 4'd0);
        vectors++; if (bus.rsp0_valid_o !== 1'b1 || bus.rsp0_res_o !== 32'h0000_F000 || bus.rsp0_tag_o !== 4'd3) begin miscompares++; $display("FAIL hold_rsp0 got v=%b res=%0h tag=%0d want v=1 res=f000 tag=3", bus.rsp0_valid_o, bus.rsp0_res_o, bus.rsp0_tag_o); end
        vectors++; if (bus.rsp1_valid_o !== 1'b1 || bus.rsp1_res_o !== 32'd16 || bus.rsp1_tag_o !== 4'd5) begin miscompares++; $display("FAIL hold_rsp1 got v=%b res=%0d tag=%0d want v=1 res=16 tag=5", bus.rsp1_valid_o, bus.rsp1_res_o, bus.rsp1_tag_o); end
    endtask

    // Drain and refill slot 0 in the same cycle, twice in a row: no bubble.
    task automatic test_back_to_back();
        bus.rsp0_ready_i = 1'b1;
        bus.rsp1_ready_i = 1'b1;
        drive0(1'b1, 2'd1, 2'd3, 32'h20, 32'd0, 32'h100, 4'd6);
        @(negedge clk);
        vectors++; if (bus.req0_ready_o !== 1'b1) begin miscompares++; $display("FAIL b2b_req0_ready_a got %b want 1", bus.req0_ready_o); end
        step();
        vectors++; if (bus.rsp0_valid_o !== 1'b1 || bus.rsp0_res_o !== 32'h120 || bus.rsp0_tag_o !== 4'd6) begin miscompares++; $display("FAIL b2b_rsp0_a got v=%b res=%0h tag=%0d want v=1 res=120 tag=6", bus.rsp0_valid_o, bus.rsp0_res_o, bus.rsp0_tag_o); end
        vectors++; if (bus.rsp1_valid_o !== 1'b0) begin miscompares++; $display("FAIL b2b_rsp1_valid got %b want 0", bus.rsp1_valid_o); end
        drive0(1'b1, 2'd2, 2'd0, 32'd0, 32'd0, 32'h200, 4'd7);
        @(negedge clk);
        vectors++; if (bus.req0_ready_o !== 1'b1) begin miscompares++; $display("FAIL b2b_req0_ready_b got %b want 1", bus.req0_ready_o); end
        step();
        drive0(1'b0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 4'd0);
        vectors++; if (bus.rsp0_valid_o !== 1'b1 || bus.rsp0_res_o !== 32'h204 || bus.rsp0_tag_o !== 4'd7) begin miscompares++; $display("FAIL b2b_rsp0_b got v=%b res=%0h tag=%0d want v=1 res=204 tag=7", bus.rsp0_valid_o, bus.rsp0_res_o, bus.rsp0_tag_o); end
        step();
    endtask

    // Fill slot 1 then slot 0 (pointer ends on port 0), reset, then a tie must go to port 0.
    task automatic test_reset_inflight();
        bus.rsp0_ready_i = 1'b0;
        bus.rsp1_ready_i = 1'b0;
        drive1(1'b1, 2'd0, 2'd3, 32'h0F, 32'hF0, 32'd0, 4'd4);
        step();
        drive1(1'b0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 4'd0);
        drive0(1'b1, 2'd0, 2'd0, 32'd7, 32'd1, 32'd0, 4'd2);
        step();
        vectors++; if (bus.rsp0_valid_o !== 1'b1 || bus.rsp1_valid_o !== 1'b1 || bus.rsp1_res_o !== 32'hFF) begin miscompares++; $display("FAIL inflight_full got v0=%b v1=%b res1=%0h want 1 1 ff", bus.rsp0_valid_o, bus.rsp1_valid_o, bus.rsp1_res_o); end
        rst = 1'b1;
        drive1(1'b1, 2'd0, 2'd0, 32'd1, 32'd1, 32'd0, 4'd8);
        @(negedge clk);
        vectors++; if (bus.req0_ready_o !== 1'b0 || bus.req1_ready_o !== 1'b0) begin miscompares++; $display("FAIL inflight_rst_ready got r0=%b r1=%b want 0 0", bus.req0_ready_o, bus.req1_ready_o); end
        step();
        vectors++; if (bus.rsp0_valid_o !== 1'b0 || bus.rsp1_valid_o !== 1'b0) begin miscompares++; $display("FAIL inflight_rst_valid got v0=%b v1=%b want 0 0", bus.rsp0_valid_o, bus.rsp1_valid_o); end
        vectors++; if (bus.rsp0_res_o !== 32'd0 || bus.rsp1_res_o !== 32'd0) begin miscompares++; $display("FAIL inflight_rst_res got %0h %0h want 0 0", bus.rsp0_res_o, bus.rsp1_res_o); end
        rst = 1'b0;
        bus.rsp0_ready_i = 1'b1;
        bus.rsp1_ready_i = 1'b1;
        @(negedge clk);
        vectors++; if (bus.req0_ready_o !== 1'b1 || bus.req1_ready_o !== 1'b0) begin miscompares++; $display("FAIL post_rst_tie got r0=%b r1=%b want 1 0", bus.req0_ready_o, bus.req1_ready_o); end
        step();
        vectors++; if (bus.rsp0_valid_o !== 1'b1 || bus.rsp0_res_o !== 32'd8 || bus.rsp1_valid_o !== 1'b0) begin miscompares++; $display("FAIL post_rst_rsp got v0=%b res0=%0d v1=%b want 1 8 0", bus.rsp0_valid_o, bus.rsp0_res_o, bus.rsp1_valid_o); end
        drive0(1'b0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 4'd0);
        drive1(1'b0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 4'd0);
        step();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_round_robin();
        test_single();
        test_hold();
        test_back_to_back();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/core_alu_arbiter.md
CORE_ALU_ARBITER -- requirements
Module: core_alu_arbiter

Interface
REQ-001 SHALL have parameter TAG_W, default 4, width of the per-request tag.
REQ-002 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports req{0,1}_valid_i  input  1 each  request valid per requester.
REQ-005 SHALL have ports req{0,1}_ready_o  output  1 each  request accepted this cycle when valid&ready.
REQ-006 SHALL have ports req{0,1}_grand_op_i, req{0,1}_op_i  input  2 each  ALU group/sub-op.
REQ-007 SHALL have ports req{0,1}_r0_i, req{0,1}_r1_i, req{0,1}_pc_i  input  32 each  operands/pc.
REQ-008 SHALL have ports req{0,1}_tag_i  input  TAG_W each  opaque tag returned with result.
REQ-009 SHALL have ports alu_grand_op_o, alu_op_o  output  2 each, and alu_r0_o, alu_r1_o, alu_pc_o  output  32 each  drive to shared ALU.
REQ-010 SHALL have port alu_res_i  input  32  combinational ALU result for the current alu_* drive.
REQ-011 SHALL have ports rsp{0,1}_valid_o  output  1 each  result slot full.
REQ-012 SHALL have ports rsp{0,1}_ready_i  input  1 each  requester consumes result.
REQ-013 SHALL have ports rsp{0,1}_res_o  output  32 each, rsp{0,1}_tag_o  output  TAG_W each.

Function
REQ-014 SHALL grant at most one requester per cycle; granted port's fields drive alu_*; no grant -> alu_* driven from port 0 fields (don't-care, no side effect).
REQ-015 SHALL make port n eligible when req_n_valid_i=1 and its result slot is EMPTY, or FULL with rsp_n_ready_i=1 this cycle.
REQ-016 SHALL arbitrate round-robin: when both eligible, grant the port not granted most recently; a single eligible port is always granted.
REQ-017 SHALL update the last-grant pointer only on a cycle with a grant.
REQ-018 SHALL assert req_n_ready_o combinationally iff port n is granted this cycle; ready SHALL NOT depend on req_n_valid_i of the other port except through arbitration.
REQ-019 SHALL capture alu_res_i and tag into slot n on the grant edge; rsp_n_valid_o rises the next cycle (latency 1).
REQ-020 SHALL keep each slot state EMPTY/FULL: EMPTY->FULL on grant; FULL->EMPTY on rsp_n_ready_i without grant; FULL->FULL with new data on simultaneous drain and grant.
REQ-021 SHALL hold rsp_n_res_o/rsp_n_tag_o stable while FULL and not drained.
REQ-022 SHALL ignore rsp_n_ready_i while slot n EMPTY.
REQ-023 SHALL sustain one accepted request per cycle per requester when its response is drained every cycle.

Reset
REQ-024 SHALL on rst=1 at a clock edge set both slots EMPTY, rsp_n_valid_o=0, last-grant pointer=port 1 (port 0 wins first tie), result/tag registers 0.
REQ-025 SHALL force req_n_ready_o=0 while rst=1; requests presented during reset are not accepted and in-flight slot contents are discarded.

Configuration
REQ-026 SHALL honour macro CORE_ALU_ARB_FIXED_PRIO_EN: defined -> port 0 always wins ties and pointer logic is removed; undefined -> round-robin per REQ-016.

Verification
REQ-027 SHALL cover: both ports valid every cycle, rsp ready=1 -> grants alternate 0,1,0,1 starting with 0; with macro defined -> port 0 every cycle, port 1 starved.
REQ-028 SHALL cover: port0 ADD r1=5 r0=3 tag=2, ALU model attached -> next cycle rsp0_valid=1, res=8, tag=2.
REQ-029 SHALL cover: rsp0_ready=0 with slot full, req0 valid -> req0_ready=0, rsp0_res held; port1 still granted.
REQ-030 SHALL cover: slot0 full, rsp0_ready=1 and req0 valid same cycle -> req0_ready=1, next cycle slot FULL with new result, no bubble.
REQ-031 SHALL cover: rst=1 while both slots FULL -> next cycle rsp valids 0, readies 0 during reset; first post-reset tie grants port 0.
